// File: rtl/decode_stage.sv
// MIPS instruction-decode pipeline stage: field split, control generation and
// immediate extension held in a valid/ready output register, with load-use bubbles.
module decode_stage #(
  parameter int PC_W      = 32,
  parameter int EXT_OPS   = 1,
  parameter int HAZARD_EN = 1,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [5:0]        out_opcode,
  output logic [5:0]        out_funct,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_shamt,
  output logic [31:0]       out_imm,
  output logic [25:0]       out_address,
  output logic              out_regwrite,
  output logic              out_memwrite,
  output logic              out_memread,
  output logic              out_regdst,
  output logic              out_alusrc,
  output logic              out_branch,
  output logic              out_branch_ne,
  output logic              out_jump,
  output logic              out_link,
  output logic              out_memtoreg,
  output logic [1:0]        out_aluop,
  output logic              out_illegal,
  output logic [CNT_W-1:0]  illegal_count
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LI   = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic       EXT_ON  = (EXT_OPS != 0);

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memread;
    logic       regdst;
    logic       alusrc;
    logic       branch;
    logic       branch_ne;
    logic       jump;
    logic       link;
    logic       memtoreg;
    logic [1:0] aluop;
  } ctrl_t;

  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  ctrl_t       ctrl_next;
  logic        illegal_next;
  logic        zero_ext;
  logic [31:0] imm_next;

  ctrl_t       ctrl_reg;
  logic [31:0] instr_reg;
  logic [31:0] imm_reg;
  logic        illegal_reg;
  logic [4:0]  ld_rt_reg;

  logic adv;
  logic hazard;
  logic accept;

  assign op = in_instr[31:26];
  assign rs = in_instr[25:21];
  assign rt = in_instr[20:16];

  always_comb begin
    ctrl_next    = '0;
    illegal_next = 1'b0;
    zero_ext     = 1'b0;
    case (op)
      OP_R: begin
        ctrl_next.regwrite = 1'b1;
        ctrl_next.regdst   = 1'b1;
        ctrl_next.aluop    = 2'b10;
      end
      OP_ADDI, OP_LI: begin
        ctrl_next.regwrite = 1'b1;
        ctrl_next.alusrc   = 1'b1;
      end
      OP_LW: begin
        ctrl_next.regwrite = 1'b1;
        ctrl_next.memread  = 1'b1;
        ctrl_next.memtoreg = 1'b1;
        ctrl_next.alusrc   = 1'b1;
      end
      OP_SW: begin
        ctrl_next.memwrite = 1'b1;
        ctrl_next.alusrc   = 1'b1;
      end
      OP_BEQ: begin
        ctrl_next.branch = 1'b1;
        ctrl_next.aluop  = 2'b01;
      end
      OP_J: ctrl_next.jump = 1'b1;
      OP_BNE: begin
        ctrl_next.branch    = EXT_ON;
        ctrl_next.branch_ne = EXT_ON;
        ctrl_next.aluop     = EXT_ON ? 2'b01 : 2'b00;
        illegal_next        = !EXT_ON;
      end
      OP_JAL: begin
        ctrl_next.jump     = EXT_ON;
        ctrl_next.link     = EXT_ON;
        ctrl_next.regwrite = EXT_ON;
        illegal_next       = !EXT_ON;
      end
      OP_SLTI, OP_ANDI, OP_ORI: begin
        ctrl_next.regwrite = EXT_ON;
        ctrl_next.alusrc   = EXT_ON;
        ctrl_next.aluop    = EXT_ON ? 2'b11 : 2'b00;
        illegal_next       = !EXT_ON;
        zero_ext           = EXT_ON && (op != OP_SLTI);
      end
      default: illegal_next = 1'b1;
    endcase
  end

  assign imm_next = zero_ext ? {16'h0000, in_instr[15:0]} : {{16{in_instr[15]}}, in_instr[15:0]};

  // Source-register usage is judged from the raw opcode, independent of EXT_OPS.
  generate
    if (HAZARD_EN != 0) begin : g_hazard
      logic reads_rs;
      logic reads_rt;
      assign reads_rs = (op != OP_J) && (op != OP_JAL);
      assign reads_rt = (op == OP_R) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
      assign hazard = in_valid && (ld_rt_reg != 5'd0) &&
                      ((reads_rs && (rs == ld_rt_reg)) || (reads_rt && (rt == ld_rt_reg)));
    end else begin : g_no_hazard
      assign hazard = 1'b0;
    end
  endgenerate

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      instr_reg     <= '0;
      imm_reg       <= '0;
      ctrl_reg      <= '0;
      illegal_reg   <= 1'b0;
      ld_rt_reg     <= 5'd0;
      illegal_count <= '0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      illegal_reg <= 1'b0;
      ld_rt_reg   <= 5'd0;
    end else if (adv) begin
      if (accept) begin
        out_valid   <= 1'b1;
        out_pc      <= in_pc;
        instr_reg   <= in_instr;
        imm_reg     <= imm_next;
        ctrl_reg    <= ctrl_next;
        illegal_reg <= illegal_next;
        ld_rt_reg   <= (op == OP_LW && rt != 5'd0) ? rt : 5'd0;
        if (illegal_next && (illegal_count != {CNT_W{1'b1}}))
          illegal_count <= illegal_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        // Bubble: the pending load has now moved far enough ahead.
        out_valid <= 1'b0;
        ld_rt_reg <= 5'd0;
      end
    end
  end

  assign out_opcode    = instr_reg[31:26];
  assign out_rs        = instr_reg[25:21];
  assign out_rt        = instr_reg[20:16];
  assign out_rd        = instr_reg[15:11];
  assign out_shamt     = instr_reg[10:6];
  assign out_funct     = instr_reg[5:0];
  assign out_address   = instr_reg[25:0];
  assign out_imm       = imm_reg;
  assign out_illegal   = illegal_reg;
  assign out_regwrite  = ctrl_reg.regwrite;
  assign out_memwrite  = ctrl_reg.memwrite;
  assign out_memread   = ctrl_reg.memread;
  assign out_regdst    = ctrl_reg.regdst;
  assign out_alusrc    = ctrl_reg.alusrc;
  assign out_branch    = ctrl_reg.branch;
  assign out_branch_ne = ctrl_reg.branch_ne;
  assign out_jump      = ctrl_reg.jump;
  assign out_link      = ctrl_reg.link;
  assign out_memtoreg  = ctrl_reg.memtoreg;
  assign out_aluop     = ctrl_reg.aluop;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected bundles are queued at accept and
// compared when the stage hands an instruction downstream.
module tb_decode_stage;

  typedef logic [134:0] bund_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_imm;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [25:0] out_address;
  logic        out_regwrite, out_memwrite, out_memread, out_regdst, out_alusrc;
  logic        out_branch, out_branch_ne, out_jump, out_link, out_memtoreg, out_illegal;
  logic [1:0]  out_aluop;
  logic [7:0]  illegal_count;

  logic        z_in_ready, z_out_valid;
  logic [31:0] z_out_pc, z_out_imm;
  logic [5:0]  z_out_opcode, z_out_funct;
  logic [4:0]  z_out_rs, z_out_rt, z_out_rd, z_out_shamt;
  logic [25:0] z_out_address;
  logic        z_out_regwrite, z_out_memwrite, z_out_memread, z_out_regdst, z_out_alusrc;
  logic        z_out_branch, z_out_branch_ne, z_out_jump, z_out_link, z_out_memtoreg, z_out_illegal;
  logic [1:0]  z_out_aluop;
  logic [7:0]  z_illegal_count;

  int    errors = 0;
  int    checks = 0;
  bund_t sbq[$];
  bund_t obs;
  bund_t sb_exp;
  bund_t hold_exp;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_opcode(out_opcode), .out_funct(out_funct), .out_rs(out_rs),
    .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt), .out_imm(out_imm),
    .out_address(out_address), .out_regwrite(out_regwrite), .out_memwrite(out_memwrite),
    .out_memread(out_memread), .out_regdst(out_regdst), .out_alusrc(out_alusrc),
    .out_branch(out_branch), .out_branch_ne(out_branch_ne), .out_jump(out_jump),
    .out_link(out_link), .out_memtoreg(out_memtoreg), .out_aluop(out_aluop),
    .out_illegal(out_illegal), .illegal_count(illegal_count)
  );

  decode_stage #(.EXT_OPS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(z_out_valid), .out_ready(out_ready),
    .out_pc(z_out_pc), .out_opcode(z_out_opcode), .out_funct(z_out_funct), .out_rs(z_out_rs),
    .out_rt(z_out_rt), .out_rd(z_out_rd), .out_shamt(z_out_shamt), .out_imm(z_out_imm),
    .out_address(z_out_address), .out_regwrite(z_out_regwrite), .out_memwrite(z_out_memwrite),
    .out_memread(z_out_memread), .out_regdst(z_out_regdst), .out_alusrc(z_out_alusrc),
    .out_branch(z_out_branch), .out_branch_ne(z_out_branch_ne), .out_jump(z_out_jump),
    .out_link(z_out_link), .out_memtoreg(z_out_memtoreg), .out_aluop(z_out_aluop),
    .out_illegal(z_out_illegal), .illegal_count(z_illegal_count)
  );

  assign obs = {out_pc, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_imm,
                out_address, out_regwrite, out_memwrite, out_memread, out_regdst, out_alusrc,
                out_branch, out_branch_ne, out_jump, out_link, out_memtoreg, out_aluop, out_illegal};

  // Control order: regwrite memwrite memread regdst alusrc branch branch_ne jump link memtoreg | aluop | illegal
  function automatic bund_t exp_bundle(input logic [31:0] ins, input logic [31:0] pc, input bit ext);
    logic [12:0] c;
    logic [31:0] imm;
    bit          zx;
    zx = 1'b0;
    case (ins[31:26])
      6'b000000:            c = 13'b1001000000_10_0;
      6'b001000, 6'b100111: c = 13'b1000100000_00_0;
      6'b100011:            c = 13'b1010100001_00_0;
      6'b101011:            c = 13'b0100100000_00_0;
      6'b000100:            c = 13'b0000010000_01_0;
      6'b000010:            c = 13'b0000000100_00_0;
      6'b000101:            c = ext ? 13'b0000011000_01_0 : 13'b0000000000_00_1;
      6'b000011:            c = ext ? 13'b1000000110_00_0 : 13'b0000000000_00_1;
      6'b001010:            c = ext ? 13'b1000100000_11_0 : 13'b0000000000_00_1;
      6'b001100, 6'b001101: begin
        c  = ext ? 13'b1000100000_11_0 : 13'b0000000000_00_1;
        zx = ext;
      end
      default:              c = 13'b0000000000_00_1;
    endcase
    imm = zx ? {16'h0000, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
    return {pc, ins[31:26], ins[25:21], ins[20:16], ins[15:11], ins[10:6], ins[5:0], imm, ins[25:0], c};
  endfunction

  // Scoreboard: a transfer happens at the coming edge when valid and ready are both high.
  always @(negedge clk) begin
    #2;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got pc=%h instr_op=%h with empty queue", out_pc, out_opcode);
      end else begin
        sb_exp = sbq.pop_front();
        if (obs !== sb_exp) begin
          errors++;
          $display("FAIL sb_bundle got %h required %h", obs, sb_exp);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, obs, illegal_count, z_illegal_count} !== '0) begin
      errors++;
      $display("FAIL reset_state got valid=%b bundle=%h cnt=%0d cnt0=%0d required all zero",
               out_valid, obs, illegal_count, z_illegal_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    @(negedge clk);
    drive(1'b1, 32'h00221820, 32'h100);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rtype_in_ready got %b required 1", in_ready); end
    sbq.push_back(exp_bundle(32'h00221820, 32'h100, 1'b1));
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if ({out_valid, out_regwrite, out_regdst, out_aluop, out_rd, out_funct} !== {3'b111, 2'b10, 5'd3, 6'h20}) begin
      errors++;
      $display("FAIL rtype_decode got v=%b rw=%b rdst=%b aluop=%b rd=%0d funct=%h required 1 1 1 10 3 20",
               out_valid, out_regwrite, out_regdst, out_aluop, out_rd, out_funct);
    end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    drive(1'b1, 32'h8D280004, 32'h104);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL lw_in_ready got %b required 1", in_ready); end
    sbq.push_back(exp_bundle(32'h8D280004, 32'h104, 1'b1));
    @(negedge clk);
    drive(1'b1, 32'h01015020, 32'h108);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL hazard_stall got in_ready=%b required 0", in_ready); end
    @(negedge clk);
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hazard_bubble got out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    sbq.push_back(exp_bundle(32'h01015020, 32'h108, 1'b1));
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if ({out_valid, out_rd, illegal_count} !== {1'b1, 5'd10, 8'd0}) begin
      errors++;
      $display("FAIL hazard_add got v=%b rd=%0d cnt=%0d required 1 10 0", out_valid, out_rd, illegal_count);
    end
  endtask

  task automatic test_imm();
    @(negedge clk);
    drive(1'b1, 32'h30628000, 32'h10C);
    sbq.push_back(exp_bundle(32'h30628000, 32'h10C, 1'b1));
    @(negedge clk);
    drive(1'b1, 32'h20628000, 32'h110);
    checks++;
    if ({in_ready, out_imm, out_aluop} !== {1'b1, 32'h00008000, 2'b11}) begin
      errors++;
      $display("FAIL andi_zext got rdy=%b imm=%h aluop=%b required 1 00008000 11", in_ready, out_imm, out_aluop);
    end
    sbq.push_back(exp_bundle(32'h20628000, 32'h110, 1'b1));
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if ({out_imm, out_aluop} !== {32'hFFFF8000, 2'b00}) begin
      errors++;
      $display("FAIL addi_sext got imm=%h aluop=%b required ffff8000 00", out_imm, out_aluop);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] prog [11];
    prog = '{32'hAC850008, 32'h1022FFFF, 32'h08123456, 32'h0C000040, 32'h2883FFFB, 32'h34E6F0F0,
             32'h9C098001, 32'h8C200010, 32'hFC000000, 32'h14220003, 32'h00031082};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(1'b1, prog[i], 32'h400 + 32'(i * 4));
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got %b required 1", i, in_ready); end
      sbq.push_back(exp_bundle(prog[i], 32'h400 + 32'(i * 4), 1'b1));
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    checks++;
    if (illegal_count !== 8'd1) begin errors++; $display("FAIL b2b_illegal_count got %0d required 1", illegal_count); end
  endtask

  task automatic test_backpressure_flush();
    @(negedge clk);
    drive(1'b1, 32'h00221820, 32'h200);
    hold_exp = exp_bundle(32'h00221820, 32'h200, 1'b1);
    sbq.push_back(hold_exp);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
      drive(1'b1, 32'h00432020, 32'h204);
      checks++;
      if ({out_valid, in_ready, obs} !== {2'b10, hold_exp}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d] got v=%b rdy=%b bundle=%h required 1 0 %h",
                 i, out_valid, in_ready, obs, hold_exp);
      end
    end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b required 0", in_ready); end
    @(negedge clk);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if ({out_valid, out_illegal} !== 2'b00) begin
      errors++;
      $display("FAIL flush_drop got out_valid=%b illegal=%b required 0 0", out_valid, out_illegal);
    end
    void'(sbq.pop_back());
    out_ready = 1'b1;
  endtask

  task automatic test_ext_off();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    sbq.delete();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive(1'b1, 32'h14220003, 32'h800 + 32'(i * 4));
      sbq.push_back(exp_bundle(32'h14220003, 32'h800 + 32'(i * 4), 1'b1));
      if (i == 1) begin
        checks++;
        if ({z_out_valid, z_out_illegal, z_out_regwrite, z_out_memwrite, z_out_memread, z_out_regdst,
             z_out_alusrc, z_out_branch, z_out_branch_ne, z_out_jump, z_out_link, z_out_memtoreg,
             z_out_aluop, z_illegal_count} !== {2'b11, 12'b0, 8'd1}) begin
          errors++;
          $display("FAIL ext0_bne_illegal got v=%b ill=%b br=%b bne=%b aluop=%b cnt=%0d required 1 1 0 0 00 1",
                   z_out_valid, z_out_illegal, z_out_branch, z_out_branch_ne, z_out_aluop, z_illegal_count);
        end
      end
    end
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    checks++;
    if ({z_illegal_count, illegal_count} !== {8'd255, 8'd0}) begin
      errors++;
      $display("FAIL illegal_saturate got cnt0=%0d cnt=%0d required 255 0", z_illegal_count, illegal_count);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 32'hFC000000, 32'h300);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0);
    checks++;
    if ({out_valid, out_illegal, illegal_count} !== {2'b11, 8'd1}) begin
      errors++;
      $display("FAIL pre_reset got v=%b ill=%b cnt=%0d required 1 1 1", out_valid, out_illegal, illegal_count);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_illegal, illegal_count} !== 10'b0) begin
      errors++;
      $display("FAIL async_reset got v=%b ill=%b cnt=%0d required 0 0 0", out_valid, out_illegal, illegal_count);
    end
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_use();
    test_imm();
    test_back_to_back();
    test_backpressure_flush();
    test_ext_off();
    test_async_reset();
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL sb_drain got %0d pending required 0", sbq.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
